// File: rtl/cpu_trace_buffer.sv
// -----------------------------------------------------------------------------
// cpu_trace_buffer
//
// Commit-trace capture stage that sits behind the single-cycle CPU top.
// Every rising clk edge while capturing, the retiring {pc, inst} pair is
// sampled into a first-word-fall-through FIFO. The consumer drains the FIFO
// through a valid/ready port. The block also spots a self-loop halt (pc
// unchanged for HALT_REPEAT consecutive samples) and counts retired
// instructions since capture was last armed.
//
// Handshake: a head entry transfers on a rising clk edge when out_valid and
// out_ready are both 1. out_valid depends only on internal state, never on
// out_ready, and stays high with stable out_pc/out_inst until the transfer.
//
// Optional feature macro: TRACE_NOP_FILTER_EN
//   defined   -> samples whose inst_in is all-zero (sll $0,$0,0) are counted
//                as retired but are not pushed into the FIFO.
//   undefined -> NOPs are pushed like any other instruction.
//
// Parameters
//   DEPTH        FIFO entries (power of 2, >= 2)
//   PTR_W        log2(DEPTH)
//   HALT_REPEAT  consecutive identical-pc samples that declare halt (>= 2)
//
// Ports
//   clk          in   1        system clock, rising edge
//   reset        in   1        asynchronous, active-low; 0 clears all state
//   pc_in        in   32       pc of the instruction retiring this cycle
//   inst_in      in   32       instruction word at pc_in
//   trace_en     in   1        1 = capture enabled, 0 = return to IDLE
//   out_valid    out  1        head entry valid (FIFO not empty)
//   out_ready    in   1        consumer accepts the head entry
//   out_pc       out  32       head entry pc, 0 when empty
//   out_inst     out  32       head entry inst, 0 when empty
//   count        out  PTR_W+1  entries held, 0..DEPTH
//   overflow     out  1        sticky: a sample was dropped on a full FIFO
//   halted       out  1        1 while the FSM sits in HALTED
//   retired_cnt  out  32       samples accepted as retired since arming
//   fsm_state    out  2        debug view of the capture FSM state
// -----------------------------------------------------------------------------
module cpu_trace_buffer #(
    parameter int DEPTH       = 16,
    parameter int PTR_W       = 4,
    parameter int HALT_REPEAT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc_in,
    input  logic [31:0]      inst_in,
    input  logic             trace_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_inst,
    output logic [PTR_W:0]   count,
    output logic             overflow,
    output logic             halted,
    output logic [31:0]      retired_cnt,
    output logic [1:0]       fsm_state
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_HALTED  = 2'd2;

    localparam int RPT_W = $clog2(HALT_REPEAT) + 1;

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);
    // repeat_cnt value that, once incremented by one more repeat, reaches
    // HALT_REPEAT-1 and therefore completes the halt pattern.
    localparam logic [RPT_W-1:0] HALT_TRIGGER = RPT_W'(HALT_REPEAT - 2);

`ifdef TRACE_NOP_FILTER_EN
    localparam bit NOP_FILTER = 1'b1;
`else
    localparam bit NOP_FILTER = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_q;
    logic [31:0]      prev_pc;
    logic [RPT_W-1:0] repeat_cnt;
    // Set on arming so the first sample is always treated as a new pc,
    // whatever prev_pc happens to hold from an earlier session.
    logic             first_sample;
    logic             overflow_q;
    logic [31:0]      retired_q;

    logic [63:0]      mem [DEPTH];

    // ------------------------------------------------------------------
    // Sample classification and next state
    // ------------------------------------------------------------------
    logic arm;
    logic sample_new;
    logic sample_repeat;

    always_comb begin
        state_nxt     = state;
        arm           = 1'b0;
        sample_new    = 1'b0;
        sample_repeat = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trace_en) begin
                    state_nxt = ST_CAPTURE;
                    arm       = 1'b1;
                end
            end
            ST_CAPTURE: begin
                // Dropping trace_en wins over a halt completing this cycle,
                // and the sample presented in that cycle is ignored.
                if (!trace_en) begin
                    state_nxt = ST_IDLE;
                end else if (first_sample || (pc_in != prev_pc)) begin
                    sample_new = 1'b1;
                end else begin
                    sample_repeat = 1'b1;
                    if (repeat_cnt == HALT_TRIGGER) begin
                        state_nxt = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
                if (!trace_en) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    logic empty;
    logic full;
    logic push;
    logic pop;
    logic wr_en;
    logic drop;

    assign empty = (count_q == '0);
    assign full  = (count_q == FULL_COUNT);
    assign push  = sample_new && !(NOP_FILTER && (inst_in == 32'h0000_0000));
    assign pop   = !empty && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still takes it.
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_q      <= '0;
            prev_pc      <= '0;
            repeat_cnt   <= '0;
            first_sample <= 1'b0;
            overflow_q   <= 1'b0;
            retired_q    <= '0;
        end else begin
            state <= state_nxt;

            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + (PTR_W + 1)'(1);
                2'b01:   count_q <= count_q - (PTR_W + 1)'(1);
                default: count_q <= count_q;
            endcase

            if (arm) begin
                overflow_q <= 1'b0;
            end else if (drop) begin
                overflow_q <= 1'b1;
            end

            // Dropped samples still retired on the CPU, so they count.
            if (arm) begin
                retired_q <= '0;
            end else if (sample_new) begin
                retired_q <= retired_q + 32'd1;
            end

            if (arm || sample_new) begin
                repeat_cnt <= '0;
            end else if (sample_repeat) begin
                repeat_cnt <= repeat_cnt + RPT_W'(1);
            end

            if (state == ST_CAPTURE && trace_en) begin
                prev_pc      <= pc_in;
                first_sample <= 1'b0;
            end else if (arm) begin
                first_sample <= 1'b1;
            end
        end
    end

    // Storage has no reset: entries are only observable once count covers
    // them, and the output mux forces zeros while empty.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {pc_in, inst_in};
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic [63:0] head;

    assign head        = mem[rd_ptr];
    assign out_valid   = !empty;
    assign out_pc      = empty ? 32'h0000_0000 : head[63:32];
    assign out_inst    = empty ? 32'h0000_0000 : head[31:0];
    assign count       = count_q;
    assign overflow    = overflow_q;
    assign halted      = (state == ST_HALTED);
    assign retired_cnt = retired_q;
    assign fsm_state   = state;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_cpu_trace_buffer
//
// Self-checking bench for cpu_trace_buffer. A behavioural model holds the
// expected FIFO contents as a queue of {pc, inst} words and tracks the
// capture mode, retired count, repeat run and overflow flag from the
// commit-trace rules. Every cycle the DUT outputs are compared to the model
// one time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_cpu_trace_buffer;

    localparam int DEPTH       = 16;
    localparam int PTR_W       = 4;
    localparam int HALT_REPEAT = 4;

`ifdef TRACE_NOP_FILTER_EN
    localparam bit NOP_FILTER = 1'b1;
`else
    localparam bit NOP_FILTER = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic reset;

    always #11 clk = ~clk;

    // ------------------------------------------------------------------
    // DUT
    // ------------------------------------------------------------------
    logic [31:0]    pc_in;
    logic [31:0]    inst_in;
    logic           trace_en;
    logic           out_valid;
    logic           out_ready;
    logic [31:0]    out_pc;
    logic [31:0]    out_inst;
    logic [PTR_W:0] count;
    logic           overflow;
    logic           halted;
    logic [31:0]    retired_cnt;
    logic [1:0]     fsm_state;

    cpu_trace_buffer #(
        .DEPTH       (DEPTH),
        .PTR_W       (PTR_W),
        .HALT_REPEAT (HALT_REPEAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .inst_in     (inst_in),
        .trace_en    (trace_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_inst    (out_inst),
        .count       (count),
        .overflow    (overflow),
        .halted      (halted),
        .retired_cnt (retired_cnt),
        .fsm_state   (fsm_state)
    );

    // ------------------------------------------------------------------
    // Scoreboard / reference model
    // ------------------------------------------------------------------
    localparam int M_IDLE    = 0;
    localparam int M_CAPTURE = 1;
    localparam int M_HALTED  = 2;

    logic [63:0] exp_q[$];
    int          m_mode;
    logic [31:0] m_prev;
    bit          m_fresh;
    int          m_repeat;
    bit          m_overflow;
    logic [31:0] m_retired;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_mode     = M_IDLE;
        m_prev     = '0;
        m_fresh    = 1'b0;
        m_repeat   = 0;
        m_overflow = 1'b0;
        m_retired  = '0;
    endtask

    // One rising edge worth of the commit-trace rules.
    task automatic model_step(input bit te, input logic [31:0] pc, input logic [31:0] inst,
                              input bit rdy);
        bit pop;
        bit push;
        int size_before;
        size_before = exp_q.size();
        pop  = rdy && (size_before > 0);
        push = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (te) begin
                    m_mode     = M_CAPTURE;
                    m_retired  = '0;
                    m_repeat   = 0;
                    m_overflow = 1'b0;
                    m_fresh    = 1'b1;
                end
            end
            M_CAPTURE: begin
                if (!te) begin
                    m_mode = M_IDLE;
                end else begin
                    if (!m_fresh && pc == m_prev) begin
                        m_repeat++;
                        if (m_repeat == HALT_REPEAT - 1) m_mode = M_HALTED;
                    end else begin
                        m_repeat  = 0;
                        m_retired = m_retired + 32'd1;
                        push      = !(NOP_FILTER && inst == 32'h0);
                    end
                    m_prev  = pc;
                    m_fresh = 1'b0;
                end
            end
            default: begin
                if (!te) m_mode = M_IDLE;
            end
        endcase
        if (pop) void'(exp_q.pop_front());
        if (push) begin
            if (size_before == DEPTH && !pop) m_overflow = 1'b1;
            else exp_q.push_back({pc, inst});
        end
    endtask

    task automatic check_all();
        logic [63:0] head;
        head = (exp_q.size() > 0) ? exp_q[0] : 64'h0;
        check_eq("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
        check_eq("count", 64'(count), 64'(exp_q.size()));
        check_eq("out_pc", 64'(out_pc), 64'(head[63:32]));
        check_eq("out_inst", 64'(out_inst), 64'(head[31:0]));
        check_eq("overflow", 64'(overflow), 64'(m_overflow));
        check_eq("halted", 64'(halted), 64'(m_mode == M_HALTED));
        check_eq("retired_cnt", 64'(retired_cnt), 64'(m_retired));
    endtask

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic cycle(input bit te, input logic [31:0] pc, input logic [31:0] inst,
                         input bit rdy);
        trace_en  = te;
        pc_in     = pc;
        inst_in   = inst;
        out_ready = rdy;
        @(posedge clk);
        model_step(te, pc, inst, rdy);
        #1;
        check_all();
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [31:0] rpc;
    bit          rte;
    bit          rrdy;
    logic [31:0] rinst;
    int          rdy_bias;

    initial begin
        reset     = 1'b0;
        trace_en  = 1'b0;
        pc_in     = '0;
        inst_in   = '0;
        out_ready = 1'b0;
        model_reset();

        // Reset state
        #5;
        check_all();
        #4 reset = 1'b1;
        for (int i = 0; i < 2; i++) cycle(1'b0, 32'h0040_0000, 32'h1234_5678, 1'b1);

        // Straight-line program, drained as it goes
        cycle(1'b1, 32'h0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 32'h0040_0000 + 32'(4 * i), 32'h2000_0000 + 32'(i), 1'b1);
        check_eq("retired_5", 64'(retired_cnt), 64'd5);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1);

        // Overflow: 20 distinct pcs with the consumer stalled
        cycle(1'b1, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 20; i++)
            cycle(1'b1, 32'h0010_0000 + 32'(4 * i), 32'hA000_0000 + 32'(i), 1'b0);
        check_eq("ovf_count", 64'(count), 64'd16);
        check_eq("ovf_flag", 64'(overflow), 64'd1);
        check_eq("ovf_retired", 64'(retired_cnt), 64'd20);
        check_eq("ovf_head", 64'(out_pc), 64'h0010_0000);
        // Full with push and pop together
        cycle(1'b1, 32'h0020_0000, 32'hBBBB_0000, 1'b1);
        check_eq("full_pushpop_count", 64'(count), 64'd16);
        check_eq("full_pushpop_ovf", 64'(overflow), 64'd1);
        for (int i = 0; i < 18; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1);

        // Halt on a self-loop
        cycle(1'b1, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h0040_000C, 32'h1000_FFFF, 1'b0);
        check_eq("halt_flag", 64'(halted), 64'd1);
        check_eq("halt_count", 64'(count), 64'd1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h0050_0000 + 32'(4 * i), 32'h1, 1'b0);
        check_eq("halt_no_capture", 64'(count), 64'd1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0);
        check_eq("halt_release", 64'(halted), 64'd0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1);

        // Asynchronous reset with seven entries held
        cycle(1'b1, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 7; i++)
            cycle(1'b1, 32'h0060_0000 + 32'(4 * i), 32'hC000_0000 + 32'(i), 1'b0);
        check_eq("pre_reset_count", 64'(count), 64'd7);
        #3 reset = 1'b0;
        #1;
        model_reset();
        check_eq("async_count", 64'(count), 64'd0);
        check_eq("async_valid", 64'(out_valid), 64'd0);
        check_eq("async_state_idle", 64'(fsm_state), 64'd0);
        check_all();
        #2 reset = 1'b1;
        cycle(1'b0, 32'h0, 32'h0, 1'b1);

        // NOP handling
        cycle(1'b1, 32'h0, 32'h0, 1'b0);
        cycle(1'b1, 32'h0000_0000, 32'h2008_0001, 1'b0);
        cycle(1'b1, 32'h0000_0004, 32'h0000_0000, 1'b0);
        cycle(1'b1, 32'h0000_0008, 32'h2009_0002, 1'b0);
        check_eq("nop_count", 64'(count), NOP_FILTER ? 64'd2 : 64'd3);
        check_eq("nop_retired", 64'(retired_cnt), 64'd3);
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1);

        // Randomized traffic
        rpc = 32'h0040_0000;
        for (int blk = 0; blk < 6; blk++) begin
            rdy_bias = $urandom_range(1, 9);
            for (int i = 0; i < 100; i++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4: rpc = rpc + 32'd4;
                    5, 6, 7:       rpc = rpc;
                    default:       rpc = {$urandom_range(0, 32'hFFFF), 2'b00};
                endcase
                rte   = ($urandom_range(0, 24) != 0);
                rinst = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
                rrdy  = ($urandom_range(0, 9) < rdy_bias);
                cycle(rte, rpc, rinst, rrdy);
            end
        end
        for (int i = 0; i < 20; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
